discrete_filter_scheduler: RTL and testbench

// - Time-multiplexed RC low-pass engine for the discrete sound voices: one shared multiplier

---
 rtl/discrete_filter_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_discrete_filter_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/discrete_filter_scheduler.sv
// Time-multiplexed first-order RC low-pass engine: one shared multiplier, y += k*(x - y) per channel.
// Optional build macro DISCRETE_SCHED_ROUND_EN selects round-half-up write-back instead of floor.
module discrete_filter_scheduler #(
  parameter int          NUM_CH      = 4,
  parameter logic [15:0] K_DEFAULT   = 16'd16384,
  parameter int          CLOCK_RATE  = 1000000,
  parameter int          SAMPLE_RATE = 48000
) (
  input  logic                 clk,
  input  logic                 I_RST,
  input  logic                 audio_clk_en,
  input  logic [NUM_CH*16-1:0] in_flat,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [15:0]          cfg_data,
  output logic [NUM_CH*16-1:0] out_flat,
  output logic                 busy,
  output logic                 sample_done,
  output logic                 overrun
);

  localparam int         RATE_RATIO = CLOCK_RATE / SAMPLE_RATE;
  localparam logic [2:0] LAST_CH    = 3'(NUM_CH - 1);

  if ((NUM_CH < 1) || (NUM_CH > 8) || (RATE_RATIO <= 3 * NUM_CH + 1)) begin : g_cfg_err
    $error("discrete_filter_scheduler: NUM_CH out of range or sample period too short for one pass");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIFF = 3'd1,
    S_MUL  = 3'd2,
    S_WB   = 3'd3,
    S_SKIP = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic [2:0]                 ch_r;
  logic [2:0]                 ch_inc_s;
  logic                       busy_r;
  logic                       sample_done_r;
  logic                       overrun_r;
  logic [NUM_CH*16-1:0]       out_flat_r;

  logic signed [15:0]         y_r    [NUM_CH];
  logic [15:0]                k_r    [NUM_CH];
  logic [15:0]                k_sh_r [NUM_CH];
  logic signed [15:0]         x_sh_r [NUM_CH];
  logic [NUM_CH-1:0]          en_sh_r;

  logic signed [16:0]         d_r;
  logic signed [33:0]         p_r;

  logic signed [15:0]         x_sel_s;
  logic signed [15:0]         y_sel_s;
  logic [15:0]                k_sel_s;
  logic                       en_next_s;
  logic [16:0]                diff_s;
  logic signed [33:0]         d_ext_s;
  logic signed [33:0]         k_ext_s;
  logic signed [33:0]         prod_s;
  logic signed [33:0]         p_adj_s;
  logic signed [15:0]         y_new_s;
  logic [NUM_CH*16-1:0]       y_all_s;

  assign ch_inc_s = ch_r + 3'd1;

  // Channel operand selection and the shared diff / multiply / write-back datapath.
  always_comb begin
    x_sel_s   = 16'sd0;
    y_sel_s   = 16'sd0;
    k_sel_s   = 16'd0;
    en_next_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      x_sel_s   = (ch_r == 3'(i))     ? x_sh_r[i]  : x_sel_s;
      y_sel_s   = (ch_r == 3'(i))     ? y_r[i]     : y_sel_s;
      k_sel_s   = (ch_r == 3'(i))     ? k_sh_r[i]  : k_sel_s;
      en_next_s = (ch_inc_s == 3'(i)) ? en_sh_r[i] : en_next_s;
    end
    diff_s  = {x_sel_s[15], x_sel_s} - {y_sel_s[15], y_sel_s};
    d_ext_s = {{17{d_r[16]}}, d_r};
    k_ext_s = {18'd0, k_sel_s};
    prod_s  = d_ext_s * k_ext_s;
`ifdef DISCRETE_SCHED_ROUND_EN
    p_adj_s = p_r + 34'sd32768;
`else
    p_adj_s = p_r;
`endif
    // k < 1 keeps the result between x and y, so the 16-bit truncation is exact.
    y_new_s = y_sel_s + 16'(p_adj_s >>> 16);
    y_all_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      y_all_s[16*i +: 16] = ((state_r == S_WB) && (ch_r == 3'(i))) ? y_new_s : y_r[i];
    end
  end

  // Next-state decode for the per-channel sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (audio_clk_en) begin
          state_next_s = ch_en[0] ? S_DIFF : S_SKIP;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_DIFF: state_next_s = S_MUL;
      S_MUL:  state_next_s = S_WB;
      S_WB, S_SKIP: begin
        if (ch_r == LAST_CH) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = en_next_s ? S_DIFF : S_SKIP;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Sequencer state, channel counter, pipeline registers and status flags.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state_r       <= S_IDLE;
      ch_r          <= 3'd0;
      busy_r        <= 1'b0;
      sample_done_r <= 1'b0;
      overrun_r     <= 1'b0;
      d_r           <= 17'sd0;
      p_r           <= 34'sd0;
    end else begin
      state_r       <= state_next_s;
      sample_done_r <= (state_next_s == S_DONE);
      if (audio_clk_en && (state_r != S_IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (audio_clk_en) begin
            ch_r   <= 3'd0;
            busy_r <= 1'b1;
          end
        end
        S_DIFF: d_r <= diff_s;
        S_MUL:  p_r <= prod_s;
        S_WB, S_SKIP: begin
          if (ch_r != LAST_CH) begin
            ch_r <= ch_inc_s;
          end
        end
        S_DONE: begin
          busy_r <= 1'b0;
          ch_r   <= 3'd0;
        end
        default: begin
          busy_r <= 1'b0;
          ch_r   <= 3'd0;
        end
      endcase
    end
  end

  // Coefficient bank and per-pass shadow copies of inputs, enables and coefficients.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        k_r[i]    <= K_DEFAULT;
        k_sh_r[i] <= K_DEFAULT;
        x_sh_r[i] <= 16'sd0;
      end
      en_sh_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && (cfg_addr == 3'(i))) begin
          k_r[i] <= cfg_data;
        end
      end
      if ((state_r == S_IDLE) && audio_clk_en) begin
        for (int i = 0; i < NUM_CH; i++) begin
          k_sh_r[i] <= k_r[i];
          x_sh_r[i] <= in_flat[16*i +: 16];
        end
        en_sh_r <= ch_en;
      end
    end
  end

  // Internal filter state and the coherent output snapshot taken on entry to DONE.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      for (int i = 0; i < NUM_CH; i++) begin
        y_r[i] <= 16'sd0;
      end
      out_flat_r <= '0;
    end else begin
      if (state_r == S_WB) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_r == 3'(i)) begin
            y_r[i] <= y_new_s;
          end
        end
      end
      if (state_next_s == S_DONE) begin
        out_flat_r <= y_all_s;
      end
    end
  end

  assign out_flat    = out_flat_r;
  assign busy        = busy_r;
  assign sample_done = sample_done_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_discrete_filter_scheduler.sv
// Directed bench for discrete_filter_scheduler: scoreboard of expected outputs and pass latency per strobe.
module tb_discrete_filter_scheduler;

  localparam int          NCH  = 4;
  localparam logic [15:0] KDEF = 16'd16384;

  logic          clk = 1'b0;
  logic          I_RST;
  logic          audio_clk_en;
  logic [63:0]   in_flat;
  logic [3:0]    ch_en;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [15:0]   cfg_data;
  logic [63:0]   out_flat;
  logic          busy;
  logic          sample_done;
  logic          overrun;

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] m_y [NCH];
  logic [15:0]        m_k [NCH];

  typedef struct {
    logic [63:0] out;
    int          lat;
  } exp_t;
  exp_t sb_q [$];

  always #5 clk = ~clk;

  discrete_filter_scheduler #(
    .NUM_CH(NCH), .K_DEFAULT(KDEF), .CLOCK_RATE(1000000), .SAMPLE_RATE(48000)
  ) dut (
    .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en), .in_flat(in_flat), .ch_en(ch_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .out_flat(out_flat),
    .busy(busy), .sample_done(sample_done), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] f_step(input logic signed [15:0] x,
                                                input logic signed [15:0] y,
                                                input logic [15:0] k);
    longint d;
    longint p;
    longint s;
    d = longint'(x) - longint'(y);
    p = d * longint'({48'd0, k});
`ifdef DISCRETE_SCHED_ROUND_EN
    p = p + 64'sd32768;
`endif
    s = longint'(y) + (p >>> 16);
    return s[15:0];
  endfunction

  function automatic logic [63:0] pack4(input logic signed [15:0] a, input logic signed [15:0] b,
                                        input logic signed [15:0] c, input logic signed [15:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] model_out();
    return {m_y[3], m_y[2], m_y[1], m_y[0]};
  endfunction

  task automatic drive_strobe(input logic [63:0] x, input logic [3:0] en);
    exp_t e;
    int   lat;
    lat = 1;
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        m_y[i] = f_step(x[16*i +: 16], m_y[i], m_k[i]);
        lat    = lat + 3;
      end else begin
        lat = lat + 1;
      end
    end
    e.out = model_out();
    e.lat = lat;
    sb_q.push_back(e);
    @(negedge clk);
    in_flat      = x;
    ch_en        = en;
    audio_clk_en = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int extra_at);
    exp_t e;
    int   cyc;
    cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        audio_clk_en = 1'b0;
        cfg_we       = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
      end
      if (c == 2) begin
        in_flat = ~in_flat;
        ch_en   = ~ch_en;
      end
      if ((extra_at != 0) && (c == extra_at)) audio_clk_en = 1'b1;
      if ((extra_at != 0) && (c == extra_at + 1)) audio_clk_en = 1'b0;
      if (sample_done) begin
        cyc = c;
        break;
      end
    end
    e = sb_q.pop_front();
    check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "_out"}, out_flat, e.out);
    @(negedge clk);
    check({tag, "_idle"}, 64'({busy, sample_done}), 64'd0);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (a < 3'd4) m_k[a[1:0]] = d;
  endtask

  initial begin
    logic [15:0] e0;
    logic [15:0] e1;
    I_RST        = 1'b1;
    audio_clk_en = 1'b0;
    in_flat      = 64'd0;
    ch_en        = 4'd0;
    cfg_we       = 1'b0;
    cfg_addr     = 3'd0;
    cfg_data     = 16'd0;
    for (int i = 0; i < NCH; i++) begin
      m_y[i] = 16'sd0;
      m_k[i] = KDEF;
    end
    repeat (3) @(negedge clk);
    check("rst_out", out_flat, 64'd0);
    check("rst_flags", 64'({busy, sample_done, overrun}), 64'd0);
    I_RST = 1'b0;

    cfg_write(3'd0, 16'd32768);
    drive_strobe(pack4(16'sd1000, -16'sd2000, 16'sd300, -16'sd7), 4'b1111);
    wait_done("s1", 0);
    check("s1_out0", {48'd0, out_flat[15:0]}, 64'd500);
    drive_strobe(pack4(16'sd1000, -16'sd2000, 16'sd300, -16'sd7), 4'b1111);
    wait_done("s2", 0);
    check("s2_out0", {48'd0, out_flat[15:0]}, 64'd750);

    drive_strobe(pack4(-16'sd3000, 16'sd12345, 16'sd4000, 16'sd20000), 4'b0101);
    wait_done("s3", 0);

    check("ovr_clear", 64'(overrun), 64'd0);
    drive_strobe(pack4(16'sd500, 16'sd500, 16'sd500, 16'sd500), 4'b1111);
    wait_done("s4", 5);
    check("ovr_set", 64'(overrun), 64'd1);
    repeat (5) @(negedge clk);
    check("ovr_sticky", 64'(overrun), 64'd1);

    cfg_write(3'd5, 16'd0);
    drive_strobe(pack4(16'sd0, 16'sd0, -16'sd10000, 16'sd0), 4'b1111);
    cfg_we   = 1'b1;
    cfg_addr = 3'd2;
    cfg_data = 16'd65535;
    m_k[2]   = 16'd65535;
    wait_done("s5", 0);
    drive_strobe(pack4(16'sd0, 16'sd0, -16'sd10000, 16'sd0), 4'b1111);
    wait_done("s6", 0);

    cfg_write(3'd3, 16'd0);
    drive_strobe(pack4(16'sd100, -16'sd100, 16'sd32000, 16'sd30000), 4'b1011);
    wait_done("s7", 0);

    @(negedge clk);
    in_flat      = pack4(16'sd9999, 16'sd9999, 16'sd9999, 16'sd9999);
    ch_en        = 4'b1111;
    audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    repeat (4) @(negedge clk);
    I_RST = 1'b1;
    #1;
    check("mid_rst_out", out_flat, 64'd0);
    check("mid_rst_flags", 64'({busy, sample_done, overrun}), 64'd0);
    @(negedge clk);
    I_RST = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_y[i] = 16'sd0;
      m_k[i] = KDEF;
    end

    drive_strobe(pack4(16'sd0, 16'sd0, 16'sd1000, 16'sd0), 4'b1111);
    wait_done("r1", 0);
    check("r1_out2", {48'd0, out_flat[47:32]}, 64'd250);

    cfg_write(3'd0, 16'd32768);
    cfg_write(3'd1, 16'd32768);
    drive_strobe(pack4(16'sd1, -16'sd1, 16'sd0, 16'sd0), 4'b1111);
    wait_done("r2", 0);
`ifdef DISCRETE_SCHED_ROUND_EN
    e0 = 16'd1;
    e1 = 16'd0;
`else
    e0 = 16'd0;
    e1 = 16'hFFFF;
`endif
    check("r2_out0", {48'd0, out_flat[15:0]}, {48'd0, e0});
    check("r2_out1", {48'd0, out_flat[31:16]}, {48'd0, e1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
